// File: rtl/cdc_dst_buffered.sv
// rtl/cdc_dst_buffered.sv - destination side of a toggle req/ack CDC with a local output FIFO
//
// Purpose:
//   Synchronises a two-phase request toggle from a foreign clock domain. Each
//   detected toggle writes the source word into a DEPTH-entry FIFO and
//   returns an acknowledge toggle. The FIFO drains through a valid/ready
//   interface, so the acknowledge does not wait for the consumer. The
//   acknowledge is held back only while the FIFO is full.
//
// Ports:
//   clk_i         destination clock
//   rst_i         synchronous reset, active-high
//   async_req_i   request toggle from the source domain (one transfer per level change)
//   async_data_i  source word, stable from req toggle until matching ack toggle
//   async_ack_o   acknowledge toggle back to the source (flop output)
//   data_o        FIFO head word
//   valid_o       FIFO non-empty
//   ready_i       consumer accepts data_o when valid_o && ready_i
//   level_o       FIFO occupancy, 0..DEPTH

module cdc_dst_buffered #(
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DEPTH       = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       async_req_i,
   input  logic [DATA_W-1:0]          async_data_i,
   output logic                       async_ack_o,
   output logic [DATA_W-1:0]          data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

   // Request synchroniser; only async_req_i crosses through flops. The data
   // bus is held stable by the source protocol and is sampled only at a push.
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   req_sync;

   logic                   req_acc_q, req_acc_d;
   logic                   ack_q, ack_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]      mem_q [DEPTH];

   logic [PW-1:0]          level;
   logic                   full;
   logic                   pending;
   logic                   push;
   logic                   pop;

   assign req_sync = sync_q[SYNC_STAGES-1];

   // Pointers carry one extra bit so full and empty are distinguishable;
   // the difference wraps naturally and gives the occupancy directly.
   assign level   = wr_ptr_q - rd_ptr_q;
   assign full    = (level == FULL_LVL);
   assign valid_o = (level != '0);

   // Level-based pending: a request blocked by a full FIFO simply stays
   // pending until a slot frees up, no edge has to be remembered.
   assign pending = (req_sync != req_acc_q);
   assign pop     = valid_o && ready_i;
   // A pop in the same cycle frees the slot the new word will occupy.
   assign push    = pending && (!full || pop);

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], async_req_i};
      req_acc_d = req_acc_q;
      ack_d     = ack_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push) begin
         req_acc_d = req_sync;
         ack_d     = ~ack_q;
         wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '0;
         req_acc_q <= 1'b0;
         ack_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         sync_q    <= sync_d;
         req_acc_q <= req_acc_d;
         ack_q     <= ack_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage is cleared on reset so data_o reads zero out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= async_data_i;
      end
   end

   assign async_ack_o = ack_q;
   assign data_o      = mem_q[rd_ptr_q[AW-1:0]];
   assign level_o     = level;

endmodule

// File: doc/cdc_dst_buffered.md
Name: cdc_dst_buffered

Overview:
Destination side of a two-phase (toggle) request/acknowledge clock-domain crossing, with the synchroniser depth and data width set by parameters. Each accepted request toggle writes one word into a local FIFO of DEPTH entries. The FIFO feeds a standard valid/ready output, so the acknowledge returns without waiting for the downstream consumer. Acknowledge is withheld only when the FIFO is full, and no word is ever dropped.

Parameters:
DATA_W, 32, width of async_data_i and data_o
SYNC_STAGES, 2, flops in the request synchroniser chain; legal values ≥2
DEPTH, 4, FIFO entries; a power of two, ≥2

Ports:
clk_i  input  1  destination clock
rst_i  input  1  synchronous reset, active-high
async_req_i  input  1  request toggle from the source domain; every level change is one transfer
async_data_i  input  DATA_W  source data; the source holds it stable from its req toggle until it sees the matching ack toggle
async_ack_o  output  1  acknowledge toggle back to the source, driven from a flop
data_o  output  DATA_W  FIFO head word
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
level_o  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: async_ack_o=0, valid_o=0, level_o=0, data_o=0, all synchroniser flops=0, req_acc=0, read/write pointers=0.
- Synchroniser:
  - async_req_i passes through SYNC_STAGES flops; the last stage is req_sync.
  - The only signal taken from the source domain is async_req_i.
  - async_data_i is sampled only at a push.
- Pending detection:
  - req_acc holds the last accepted request level.
  - pending = (req_sync != req_acc).
  - pending is level-based, so a request that cannot be taken stays pending with no edge memory.
- Push (clock edge where pending && (level_o<DEPTH || pop)):
  - async_data_i is written at the write pointer.
  - req_acc <= req_sync.
  - async_ack_o <= ~async_ack_o.
  - The write pointer advances.
- Pop (clock edge where valid_o && ready_i): the read pointer advances.
- Occupancy per cycle:
  - push only: level +1
  - pop only: level −1
  - push and pop together: level unchanged
- Simultaneous push and pop at full (level_o==DEPTH) is legal. The new word takes the freed slot.
- At full without a pop: async_ack_o stays constant and pending is held. The push happens on the first cycle a pop occurs.
- data_o / valid_o:
  - valid_o = (level_o != 0).
  - data_o = memory[read pointer].
  - While valid_o && !ready_i, data_o stays stable.
  - data_o is don't-care when valid_o=0, but the bench checks it only when valid_o=1.
- Latency, with the req toggle set up before edge n:
  - req_sync changes after edge n+SYNC_STAGES−1.
  - The push and the ack toggle happen at edge n+SYNC_STAGES.
  - valid_o is high after edge n+SYNC_STAGES if the FIFO was empty.
  - For SYNC_STAGES=2 this is 3 edges.
- Throughput: at most one transfer per source round-trip. The destination never generates more than one push per req toggle.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full is level_o==DEPTH; empty is level_o==0.
- Reset mid-operation:
  - FIFO contents, pending requests and the ack phase are discarded.
  - The source domain must be reset in the same window so that async_req_i returns to 0.
  - A req toggle that is still in the synchroniser at reset is discarded.
- Protocol violation: a second req toggle before the ack is undefined. The block needs no detection logic for it.

Test Plan:
- Single transfer, DATA_W=8, SYNC_STAGES=2, DEPTH=4: data=0xA5, toggle req 0→1 -> async_ack_o becomes 1 exactly 2 edges after req is sampled, valid_o=1 with data_o=0xA5, level_o=1; ready_i=1 -> valid_o=0 next cycle.
- Back-to-back with ready_i=1: a source model sends 0x01..0x08, toggling on each ack -> all 8 words appear in order, no duplicates, level_o never exceeds 1 beyond the pending cycle.
- Backpressure fill with ready_i=0: send 0x10..0x14 -> after 4 pushes level_o=4 and the 5th ack is not toggled; the 5th request stays pending for 20 cycles with async_ack_o unchanged.
- Release from full: in the previous state, pulse ready_i for one cycle -> that cycle pops 0x10 and pushes 0x14, level_o stays 4, async_ack_o toggles; draining then yields 0x11,0x12,0x13,0x14.
- Simultaneous push and pop at level 2: the pop and the sync-detected req coincide -> level_o stays 2, order preserved.
- Reset mid-operation with level_o=3 and one req in flight: assert rst_i for 2 cycles and reset the source -> valid_o=0, level_o=0, async_ack_o=0; a new transfer 0x5A then completes normally.
